count_sequence_checker: RTL and testbench

Receive-side checker for the 16-state non-binary count sequence 1,3,5,0,2,4,6,7,8,9,10,15,14,13,12,11,(1…) produced by the sequential counter. It samples a 4-bit count stream qualified by a valid strobe and acquires lock on the sequence. While locked it flags every out-of-order value and keeps a saturating error tally. It sits downstream of the counter, or at the far end of any link carrying its value, as a built-in self-check.

---
 rtl/count_sequence_checker.sv | 190 +++++++++++++++++++
 tb/tb_count_sequence_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : count_sequence_checker
//  Purpose  : Receive-side checker for the 16-state count sequence
//             1,3,5,0,2,4,6,7,8,9,10,15,14,13,12,11 (then back to 1).
//             It acquires lock on a valid-qualified 4-bit stream. While
//             locked it flags out-of-order samples and keeps a saturating
//             error tally.
//  Ports    : clk        - rising-edge clock
//             rst_n      - synchronous active-low reset
//             in_valid   - in_count is sampled when high
//             in_count   - received count value
//             locked     - high while tracking is locked
//             err_pulse  - one-cycle pulse on a mismatch while locked
//             expected   - value the next valid sample must carry
//             pos        - sequence index of the last accepted sample
//             wrap_pulse - one-cycle pulse on an accepted 11->1 while locked
//             err_cnt    - saturating count of err_pulse events
//  Revision : 1.0  initial release
// ============================================================================
module count_sequence_checker #(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_count,
    output logic             locked,
    output logic             err_pulse,
    output logic [3:0]       expected,
    output logic [3:0]       pos,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] c_LOCK_CNT   = LOCK_CNT[3:0];
    localparam logic [3:0] c_UNLOCK_CNT = UNLOCK_CNT[3:0];
    localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Successor of each value in the count sequence.
    function automatic logic [3:0] succ_of(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'd1:    s = 4'd3;
            4'd3:    s = 4'd5;
            4'd5:    s = 4'd0;
            4'd0:    s = 4'd2;
            4'd2:    s = 4'd4;
            4'd4:    s = 4'd6;
            4'd6:    s = 4'd7;
            4'd7:    s = 4'd8;
            4'd8:    s = 4'd9;
            4'd9:    s = 4'd10;
            4'd10:   s = 4'd15;
            4'd15:   s = 4'd14;
            4'd14:   s = 4'd13;
            4'd13:   s = 4'd12;
            4'd12:   s = 4'd11;
            default: s = 4'd1;   // 11 wraps back to 1
        endcase
        return s;
    endfunction

    // Position of each value within the count sequence.
    function automatic logic [3:0] idx_of(input logic [3:0] v);
        logic [3:0] p;
        case (v)
            4'd1:    p = 4'd0;
            4'd3:    p = 4'd1;
            4'd5:    p = 4'd2;
            4'd0:    p = 4'd3;
            4'd2:    p = 4'd4;
            4'd4:    p = 4'd5;
            4'd6:    p = 4'd6;
            4'd7:    p = 4'd7;
            4'd8:    p = 4'd8;
            4'd9:    p = 4'd9;
            4'd10:   p = 4'd10;
            4'd15:   p = 4'd11;
            4'd14:   p = 4'd12;
            4'd13:   p = 4'd13;
            4'd12:   p = 4'd14;
            default: p = 4'd15;  // 11 is the last element
        endcase
        return p;
    endfunction

    state_t           r_state;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_wrap_pulse;
    logic [3:0]       r_expected;
    logic [3:0]       r_pos;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_hit;
    logic [3:0]       w_match_next;
    logic [3:0]       w_miss_next;

    assign w_hit        = (in_count == r_expected);
    assign w_match_next = r_match_cnt + 4'd1;
    assign w_miss_next  = r_miss_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_match_cnt  <= 4'd0;
            r_miss_cnt   <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_expected   <= 4'd1;
            r_pos        <= 4'd0;
            r_err_cnt    <= '0;
        end else begin
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            if (in_valid) begin
                // Every branch (match, mismatch reseed, resync) continues
                // tracking from the sample just received.
                r_pos      <= idx_of(in_count);
                r_expected <= succ_of(in_count);
                case (r_state)
                    HUNT: begin
                        r_match_cnt <= 4'd0;
                        r_state     <= ACQ;
                    end
                    ACQ: begin
                        if (w_hit) begin
                            r_match_cnt <= w_match_next;
                            if (w_match_next == c_LOCK_CNT) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= 4'd0;
                            end
                        end else begin
                            r_match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (w_hit) begin
                            r_miss_cnt <= 4'd0;
                            // A hit on 1 can only follow 11 in this sequence,
                            // the pos check keeps the intent explicit.
                            r_wrap_pulse <= (in_count == 4'd1) && (r_pos == 4'd15);
                        end else begin
                            r_err_pulse <= 1'b1;
                            if (!(&r_err_cnt)) begin
                                r_err_cnt <= r_err_cnt + c_ERR_ONE;
                            end
                            if (w_miss_next == c_UNLOCK_CNT) begin
                                r_state     <= ACQ;
                                r_locked    <= 1'b0;
                                r_match_cnt <= 4'd0;
                                r_miss_cnt  <= 4'd0;
                            end else begin
                                r_miss_cnt <= w_miss_next;
                            end
                        end
                    end
                    default: begin
                        r_state     <= HUNT;
                        r_locked    <= 1'b0;
                        r_match_cnt <= 4'd0;
                        r_miss_cnt  <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign expected   = r_expected;
    assign pos        = r_pos;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_count_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_sequence_checker
//  Purpose  : Self-checking bench for count_sequence_checker. Two instances
//             (ERR_W=8 and ERR_W=2) share one directed stimulus stream and
//             are compared every cycle against a sequence-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_sequence_checker;

    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_count = 4'd0;

    logic       a_locked, a_err_pulse, a_wrap_pulse;
    logic [3:0] a_expected, a_pos;
    logic [7:0] a_err_cnt;

    logic       b_locked, b_err_pulse, b_wrap_pulse;
    logic [3:0] b_expected, b_pos;
    logic [1:0] b_err_cnt;

    count_sequence_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .locked(a_locked), .err_pulse(a_err_pulse), .expected(a_expected),
        .pos(a_pos), .wrap_pulse(a_wrap_pulse), .err_cnt(a_err_cnt)
    );

    count_sequence_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .locked(b_locked), .err_pulse(b_err_pulse), .expected(b_expected),
        .pos(b_pos), .wrap_pulse(b_wrap_pulse), .err_cnt(b_err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, req);
        end
    endtask

    // ---------------- sequence-level model ----------------
    int seq [16] = '{1, 3, 5, 0, 2, 4, 6, 7, 8, 9, 10, 15, 14, 13, 12, 11};

    function automatic int idx_of(input int v);
        for (int i = 0; i < 16; i++) begin
            if (seq[i] == v) return i;
        end
        return 0;
    endfunction

    bit m_seeded, m_locked, m_err, m_wrap, checking;
    int m_streak, m_miss, m_errs, m_exp, m_pos, m_last;

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            checking = 1'b1;
            m_seeded = 0; m_locked = 0; m_err = 0; m_wrap = 0;
            m_streak = 0; m_miss = 0; m_errs = 0; m_exp = 1; m_pos = 0; m_last = 0;
        end else begin
            m_err  = 0;
            m_wrap = 0;
            if (in_valid) begin
                int v;
                bit hit;
                v   = int'(in_count);
                hit = (v == m_exp);
                if (!m_seeded) begin
                    m_seeded = 1;
                    m_streak = 0;
                end else if (!m_locked) begin
                    m_streak = hit ? m_streak + 1 : 0;
                    if (m_streak == LOCK_CNT) begin
                        m_locked = 1;
                        m_miss   = 0;
                    end
                end else if (hit) begin
                    m_miss = 0;
                    m_wrap = (v == 1) && (m_last == 11);
                end else begin
                    m_err = 1;
                    m_errs++;
                    m_miss++;
                    if (m_miss == UNLOCK_CNT) begin
                        m_locked = 0;
                        m_streak = 0;
                        m_miss   = 0;
                    end
                end
                m_pos  = idx_of(v);
                m_exp  = seq[(m_pos + 1) % 16];
                m_last = v;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("a_locked",   a_locked,     m_locked);
            chk("a_err",      a_err_pulse,  m_err);
            chk("a_wrap",     a_wrap_pulse, m_wrap);
            chk("a_expected", a_expected,   m_exp);
            chk("a_pos",      a_pos,        m_pos);
            chk("a_err_cnt",  a_err_cnt,    sat(m_errs, 255));
            chk("b_locked",   b_locked,     m_locked);
            chk("b_err",      b_err_pulse,  m_err);
            chk("b_wrap",     b_wrap_pulse, m_wrap);
            chk("b_expected", b_expected,   m_exp);
            chk("b_pos",      b_pos,        m_pos);
            chk("b_err_cnt",  b_err_cnt,    sat(m_errs, 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic vld, input logic [3:0] v);
        @(negedge clk);
        in_valid = vld;
        in_count = v;
    endtask

    task automatic look();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 4'd0);
    endtask

    initial begin
        logic [3:0] burst [16];

        repeat (3) @(negedge clk);
        chk("rst_locked",   a_locked,   0);
        chk("rst_expected", a_expected, 1);
        chk("rst_pos",      a_pos,      0);
        chk("rst_err_cnt",  a_err_cnt,  0);
        rst_n = 1'b1;

        // acquisition back-to-back
        send(1, 4'd1); send(1, 4'd3); send(1, 4'd5); send(1, 4'd0);
        look();
        chk("lock_locked",   a_locked,   1);
        chk("lock_expected", a_expected, 2);
        chk("lock_pos",      a_pos,      3);
        chk("lock_err_cnt",  a_err_cnt,  0);

        // single mismatch while locked
        send(1, 4'd7);
        look();
        chk("miss1_err",      a_err_pulse, 1);
        chk("miss1_err_cnt",  a_err_cnt,   1);
        chk("miss1_locked",   a_locked,    1);
        chk("miss1_expected", a_expected,  8);
        send(1, 4'd8);
        look();
        chk("resync_err",    a_err_pulse, 0);
        chk("resync_locked", a_locked,    1);

        // two consecutive mismatches drop lock
        send(1, 4'd4);
        send(1, 4'd4);
        look();
        chk("unlock_locked",   a_locked,   0);
        chk("unlock_err_cnt",  a_err_cnt,  3);
        chk("unlock_expected", a_expected, 6);
        send(1, 4'd6); send(1, 4'd7); send(1, 4'd8);
        look();
        chk("relock_locked", a_locked, 1);

        // full loop through the wrap point
        burst = '{4'd9, 4'd10, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd1,
                  4'd3, 4'd5, 4'd0, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8};
        for (int i = 0; i < 8; i++) send(1, burst[i]);
        look();
        chk("wrap_pulse", a_wrap_pulse, 1);
        chk("wrap_pos",   a_pos,        0);
        chk("wrap_err",   a_err_cnt,    3);
        for (int i = 8; i < 16; i++) send(1, burst[i]);

        // alternating mismatch/match, five mismatches
        send(1, 4'd0); send(1, 4'd2); send(1, 4'd7); send(1, 4'd8);
        send(1, 4'd1); send(1, 4'd3); send(1, 4'd12);
        look();
        chk("sat_b_err",     b_err_pulse, 1);
        chk("sat_b_err_cnt", b_err_cnt,   3);
        send(1, 4'd11); send(1, 4'd6); send(1, 4'd7);
        look();
        chk("alt_a_err_cnt", a_err_cnt, 8);
        chk("alt_b_err_cnt", b_err_cnt, 3);
        chk("alt_locked",    a_locked,  1);
        chk("alt_expected",  a_expected, 8);

        // reset with a sample present
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_count = 4'd2;
        look();
        chk("rst2_locked",   a_locked,   0);
        chk("rst2_expected", a_expected, 1);
        chk("rst2_pos",      a_pos,      0);
        chk("rst2_err_cnt",  a_err_cnt,  0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        // sparse samples
        send(1, 4'd1); idle(3);
        send(1, 4'd3); idle(3);
        send(1, 4'd5); idle(3);
        chk("gap_prelock", a_locked, 0);
        send(1, 4'd0);
        look();
        chk("gap_locked",   a_locked,   1);
        chk("gap_expected", a_expected, 2);
        chk("gap_pos",      a_pos,      3);

        // reseed during acquisition raises no error
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 4'd1); send(1, 4'd3); send(1, 4'd9); send(1, 4'd10); send(1, 4'd15);
        look();
        chk("reseed_locked",   a_locked,    0);
        chk("reseed_err",      a_err_cnt,   0);
        chk("reseed_expected", a_expected, 14);
        send(1, 4'd14);
        look();
        chk("reseed_lock",     a_locked,    1);
        chk("reseed_exp2",     a_expected, 13);

        idle(3);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
